// File: rtl/idma_cmpl_tracker_if.sv
// Handshake bundle between the job FIFO/midend, the tracker and the iDMA backend.
// Names follow the tracker's view; slave = tracker side, master = environment side.
interface idma_cmpl_tracker_if #(
  parameter int unsigned AddrWidth = 64
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_valid_o;
  logic                 req_ready_i;
  logic                 rsp_valid_i;
  logic                 rsp_ready_o;
  logic                 rsp_error_i;
  logic [AddrWidth-1:0] rsp_err_addr_i;

  modport slave (
    input  req_valid_i,
    output req_ready_o,
    output req_valid_o,
    input  req_ready_i,
    input  rsp_valid_i,
    output rsp_ready_o,
    input  rsp_error_i,
    input  rsp_err_addr_i
  );

  modport master (
    output req_valid_i,
    input  req_ready_o,
    input  req_valid_o,
    output req_ready_i,
    output rsp_valid_i,
    input  rsp_ready_o,
    output rsp_error_i,
    output rsp_err_addr_i
  );
endinterface

// File: rtl/idma_cmpl_tracker.sv
// Job accounting for the iDMA backend: request gating is combinational, counters/irq/error regs 1 cycle.
// Backpressure: issue stalls when MaxOutstanding jobs are in flight; responses are refused when none are.
module idma_cmpl_tracker #(
  parameter int unsigned IdWidth        = 32,
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  idma_cmpl_tracker_if.slave   bus,
  input  logic                 irq_en_i,
  input  logic                 irq_ack_i,
  input  logic                 err_clear_i,
  output logic [IdWidth-1:0]   next_id_o,
  output logic [IdWidth-1:0]   done_id_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 busy_o,
  output logic                 irq_o,
  output logic                 err_valid_o,
  output logic [IdWidth-1:0]   err_id_o,
  output logic [AddrWidth-1:0] err_addr_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  logic full;
  logic issue;
  logic retire;
  logic err_set;
  logic irq_set;

  // Gates depend on registered state only, keeping rsp and req paths independent.
  assign full            = (outstanding_o == MaxCnt);
  assign bus.req_valid_o = bus.req_valid_i & ~full;
  assign bus.req_ready_o = bus.req_ready_i & ~full;
  assign bus.rsp_ready_o = (outstanding_o != '0);

  assign issue   = bus.req_valid_o & bus.req_ready_i;
  assign retire  = bus.rsp_valid_i & bus.rsp_ready_o;
  assign err_set = retire & bus.rsp_error_i & (~err_valid_o | err_clear_i);
  assign irq_set = retire & (irq_en_i | bus.rsp_error_i);
  assign busy_o  = (outstanding_o != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_id_o     <= '0;
      done_id_o     <= '0;
      outstanding_o <= '0;
    end else begin
      if (issue) next_id_o <= next_id_o + IdWidth'(1);
      if (retire) done_id_o <= done_id_o + IdWidth'(1);
      if (issue && !retire) begin
        outstanding_o <= outstanding_o + CntWidth'(1);
      end else if (retire && !issue) begin
        outstanding_o <= outstanding_o - CntWidth'(1);
      end
    end
  end

  // First error is sticky until cleared; a coincident new error beats the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_o <= 1'b0;
      err_id_o    <= '0;
      err_addr_o  <= '0;
    end else if (err_set) begin
      err_valid_o <= 1'b1;
      err_id_o    <= done_id_o;
      err_addr_o  <= bus.rsp_err_addr_i;
    end else if (err_clear_i) begin
      err_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_o <= 1'b0;
    end else if (irq_set) begin
      irq_o <= 1'b1;
    end else if (irq_ack_i) begin
      irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idma_cmpl_tracker.sv
// Directed bench for idma_cmpl_tracker with IdWidth=4, MaxOutstanding=4.
module tb_idma_cmpl_tracker;

  localparam int unsigned IdW  = 4;
  localparam int unsigned MaxO = 4;
  localparam int unsigned AW   = 64;
  localparam int unsigned CW   = $clog2(MaxO + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          irq_en = 1'b0;
  logic          irq_ack = 1'b0;
  logic          err_clear = 1'b0;
  logic [IdW-1:0] next_id;
  logic [IdW-1:0] done_id;
  logic [CW-1:0]  outstanding;
  logic           busy;
  logic           irq;
  logic           err_valid;
  logic [IdW-1:0] err_id;
  logic [AW-1:0]  err_addr;

  int errors = 0;
  int checks = 0;

  idma_cmpl_tracker_if #(.AddrWidth(AW)) bus ();

  idma_cmpl_tracker #(
    .IdWidth(IdW),
    .MaxOutstanding(MaxO),
    .AddrWidth(AW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus),
    .irq_en_i(irq_en),
    .irq_ack_i(irq_ack),
    .err_clear_i(err_clear),
    .next_id_o(next_id),
    .done_id_o(done_id),
    .outstanding_o(outstanding),
    .busy_o(busy),
    .irq_o(irq),
    .err_valid_o(err_valid),
    .err_id_o(err_id),
    .err_addr_o(err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [63:0] nid, input logic [63:0] did,
                           input logic [63:0] outs);
    chk({tag, ".next_id"}, 64'(next_id), nid);
    chk({tag, ".done_id"}, 64'(done_id), did);
    chk({tag, ".outstanding"}, 64'(outstanding), outs);
  endtask

  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_ready_i    = 1'b0;
    bus.rsp_valid_i    = 1'b0;
    bus.rsp_error_i    = 1'b0;
    bus.rsp_err_addr_i = '0;

    // Reset state
    #12;
    chk_state("rst", 64'd0, 64'd0, 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.irq", 64'(irq), 64'd0);
    chk("rst.err_valid", 64'(err_valid), 64'd0);
    chk("rst.err_id", 64'(err_id), 64'd0);
    chk("rst.err_addr", err_addr, 64'd0);
    chk("rst.req_valid_o", 64'(bus.req_valid_o), 64'd0);
    chk("rst.req_ready_o", 64'(bus.req_ready_o), 64'd0);
    chk("rst.rsp_ready_o", 64'(bus.rsp_ready_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // First issue and fill to MaxOutstanding
    bus.req_valid_i = 1'b1;
    bus.req_ready_i = 1'b1;
    #1;
    chk("idle.req_valid_o", 64'(bus.req_valid_o), 64'd1);
    chk("idle.req_ready_o", 64'(bus.req_ready_o), 64'd1);
    tick();
    chk_state("issue1", 64'd1, 64'd0, 64'd1);
    chk("issue1.busy", 64'(busy), 64'd1);
    tick();
    tick();
    tick();
    chk_state("full", 64'd4, 64'd0, 64'd4);
    chk("full.req_ready_o", 64'(bus.req_ready_o), 64'd0);
    chk("full.req_valid_o", 64'(bus.req_valid_o), 64'd0);
    chk("full.rsp_ready_o", 64'(bus.rsp_ready_o), 64'd1);
    tick();
    chk_state("full_hold", 64'd4, 64'd0, 64'd4);

    // Retire while full: same-cycle issue stays blocked
    bus.rsp_valid_i = 1'b1;
    tick();
    bus.rsp_valid_i = 1'b0;
    chk_state("full_retire", 64'd4, 64'd1, 64'd3);
    chk("full_retire.irq", 64'(irq), 64'd0);
    chk("unfull.req_ready_o", 64'(bus.req_ready_o), 64'd1);
    tick();
    chk_state("fifth", 64'd5, 64'd1, 64'd4);

    // Drain to 2, then simultaneous issue + retire
    bus.req_valid_i = 1'b0;
    bus.rsp_valid_i = 1'b1;
    tick();
    tick();
    chk_state("drain2", 64'd5, 64'd3, 64'd2);
    bus.req_valid_i = 1'b1;
    tick();
    chk_state("simul", 64'd6, 64'd4, 64'd2);
    bus.rsp_valid_i = 1'b0;

    // Asynchronous reset mid-burst
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("arst", 64'd0, 64'd0, 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.rsp_ready_o", 64'(bus.rsp_ready_o), 64'd0);
    bus.req_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Errors: issue IDs 0..3, errors on 1 and 3 with irq_en low
    bus.req_valid_i = 1'b1;
    repeat (4) tick();
    bus.req_valid_i = 1'b0;
    chk_state("err_fill", 64'd4, 64'd0, 64'd4);
    bus.rsp_valid_i = 1'b1;
    tick();
    chk("err.irq_noerr", 64'(irq), 64'd0);
    bus.rsp_error_i    = 1'b1;
    bus.rsp_err_addr_i = 64'h1000;
    tick();
    chk("err1.valid", 64'(err_valid), 64'd1);
    chk("err1.id", 64'(err_id), 64'd1);
    chk("err1.addr", err_addr, 64'h1000);
    chk("err1.irq", 64'(irq), 64'd1);
    bus.rsp_error_i = 1'b0;
    tick();
    bus.rsp_error_i    = 1'b1;
    bus.rsp_err_addr_i = 64'h3000;
    tick();
    chk("err3.id_held", 64'(err_id), 64'd1);
    chk("err3.addr_held", err_addr, 64'h1000);
    chk_state("err_drained", 64'd4, 64'd4, 64'd0);
    chk("empty.rsp_ready_o", 64'(bus.rsp_ready_o), 64'd0);
    tick();
    chk_state("no_underflow", 64'd4, 64'd4, 64'd0);
    bus.rsp_valid_i = 1'b0;
    bus.rsp_error_i = 1'b0;

    // Error capture coinciding with clear: set wins
    bus.req_valid_i = 1'b1;
    tick();
    tick();
    bus.req_valid_i = 1'b0;
    bus.rsp_valid_i = 1'b1;
    tick();
    bus.rsp_error_i    = 1'b1;
    bus.rsp_err_addr_i = 64'h5000;
    err_clear          = 1'b1;
    tick();
    chk("clr_set.valid", 64'(err_valid), 64'd1);
    chk("clr_set.id", 64'(err_id), 64'd5);
    chk("clr_set.addr", err_addr, 64'h5000);
    bus.rsp_valid_i = 1'b0;
    bus.rsp_error_i = 1'b0;
    tick();
    err_clear = 1'b0;
    chk("clr.valid", 64'(err_valid), 64'd0);

    // IRQ: ack alone clears, retire with irq_en beats coincident ack
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("ack.irq", 64'(irq), 64'd0);
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    irq_en          = 1'b1;
    irq_ack         = 1'b1;
    bus.rsp_valid_i = 1'b1;
    tick();
    bus.rsp_valid_i = 1'b0;
    irq_en          = 1'b0;
    chk("irq_set_wins", 64'(irq), 64'd1);
    chk_state("irq_retire", 64'd7, 64'd7, 64'd0);
    tick();
    irq_ack = 1'b0;
    chk("irq_ack", 64'(irq), 64'd0);

    // Wrap: complete 20 jobs total since reset
    bus.req_valid_i = 1'b1;
    bus.rsp_valid_i = 1'b1;
    repeat (13) tick();
    bus.req_valid_i = 1'b0;
    chk_state("wrap_mid", 64'd4, 64'd3, 64'd1);
    tick();
    bus.rsp_valid_i = 1'b0;
    chk_state("wrap", 64'd4, 64'd4, 64'd0);
    chk("wrap.busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
